// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the pipeline dmem port and the responder
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_req_we;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0] dmem_dataIn;
  logic                  dmem_resp_valid;
  logic                  dmem_resp_we;
  logic                  dmem_resp_err;
  logic [DATA_WIDTH-1:0] dmem_dataOut;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_address, dmem_dataIn,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_we, dmem_resp_err, dmem_dataOut
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_address, dmem_dataIn,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_we, dmem_resp_err, dmem_dataOut
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory with programmable wait states
// Requests are serialised: accept, count WAIT_CYCLES, commit and answer for one cycle.
module dmem_responder #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  cm_we;
  logic                  cm_in_range;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [IDX_W-1:0]      cm_idx;

  assign bus.dmem_req_ready = (state != S_WAIT);
  assign accept             = bus.dmem_req_valid && bus.dmem_req_ready;

  // With zero wait states the accept edge is also the commit edge, so the live request is used.
  always_comb begin
    cm_we   = cap_we;
    cm_addr = cap_addr;
    cm_data = cap_data;
    commit  = 1'b0;
    if (state == S_WAIT) begin
      commit = (wait_cnt == 4'd1);
    end else if (ZERO_WAIT) begin
      cm_we   = bus.dmem_req_we;
      cm_addr = bus.dmem_address;
      cm_data = bus.dmem_dataIn;
      commit  = accept;
    end
    cm_in_range = (cm_addr < ADDR_WIDTH'(DEPTH));
    cm_idx      = cm_addr[IDX_W-1:0];
  end

  // Array is not reset; a store only lands on its commit edge while out of reset.
  always_ff @(posedge clk) begin
    if (rst && commit && cm_we && cm_in_range) begin
      mem[cm_idx] <= cm_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      wait_cnt            <= 4'd0;
      cap_we              <= 1'b0;
      cap_addr            <= '0;
      cap_data            <= '0;
      bus.dmem_resp_valid <= 1'b0;
      bus.dmem_resp_we    <= 1'b0;
      bus.dmem_resp_err   <= 1'b0;
      bus.dmem_dataOut    <= '0;
    end else begin
      if (commit) begin
        bus.dmem_resp_valid <= 1'b1;
        bus.dmem_resp_we    <= cm_we;
        bus.dmem_resp_err   <= !cm_in_range;
        if (!cm_we) begin
          bus.dmem_dataOut <= cm_in_range ? mem[cm_idx] : '0;
        end
      end else begin
        bus.dmem_resp_valid <= 1'b0;
        bus.dmem_resp_err   <= 1'b0;
      end

      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            cap_we   <= bus.dmem_req_we;
            cap_addr <= bus.dmem_address;
            cap_data <= bus.dmem_dataIn;
            wait_cnt <= WAIT_INIT;
            state    <= ZERO_WAIT ? S_RESP : S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at two wait-state settings
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_dmem_responder;
  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    logic        we;
    logic        err;
    logic [63:0] data;
    int          at;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [63:0] mem_a [logic [31:0]];
  logic [63:0] mem_b [logic [31:0]];
  logic [63:0] last_a;
  logic [63:0] last_b;

  dmem_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if_a ();
  dmem_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if_b ();

  dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic mon_check(input bit sel, input logic we, input logic err, input logic [63:0] data);
    exp_t e;
    tests++;
    if ((sel && q_b.size() == 0) || (!sel && q_a.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_resp dut%0d: got we=%b err=%b data=%h at %0d, required none", sel, we, err, data, cyc);
      return;
    end
    if (sel) e = q_b.pop_front();
    else     e = q_a.pop_front();
    if (we !== e.we || err !== e.err || data !== e.data || cyc != e.at) begin
      fails++;
      $display("FAIL resp dut%0d: got we=%b err=%b data=%h at %0d, required we=%b err=%b data=%h at %0d",
               sel, we, err, data, cyc, e.we, e.err, e.data, e.at);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (if_a.dmem_resp_valid)
          mon_check(1'b0, if_a.dmem_resp_we, if_a.dmem_resp_err, if_a.dmem_dataOut);
        if (if_b.dmem_resp_valid)
          mon_check(1'b1, if_b.dmem_resp_we, if_b.dmem_resp_err, if_b.dmem_dataOut);
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic issue(input bit sel, input bit we, input logic [31:0] addr, input logic [63:0] data,
                       input bit expect_resp = 1'b1);
    bit          r;
    bit          done;
    int          acc;
    exp_t        e;
    logic [63:0] ed;
    done = 1'b0;
    acc  = 0;
    if (sel) begin
      if_b.dmem_req_valid = 1'b1; if_b.dmem_req_we = we; if_b.dmem_address = addr; if_b.dmem_dataIn = data;
    end else begin
      if_a.dmem_req_valid = 1'b1; if_a.dmem_req_we = we; if_a.dmem_address = addr; if_a.dmem_dataIn = data;
    end
    for (int t = 0; t < 20 && !done; t++) begin
      r = sel ? if_b.dmem_req_ready : if_a.dmem_req_ready;
      if (sel) check("w0_ready_always", {63'd0, r}, 64'd1);
      @(posedge clk);
      #1;
      if (r) begin
        done = 1'b1;
        acc  = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout dut%0d: got no accept, required accept within 20 cycles", sel);
    end else if (expect_resp) begin
      e.we  = we;
      e.err = (addr >= 32'd256);
      if (we) begin
        if (!e.err) begin
          if (sel) mem_b[addr] = data;
          else     mem_a[addr] = data;
        end
        ed = sel ? last_b : last_a;
      end else begin
        if (e.err) ed = 64'd0;
        else       ed = sel ? mem_b[addr] : mem_a[addr];
        if (sel) last_b = ed;
        else     last_a = ed;
      end
      e.data = ed;
      e.at   = acc + (sel ? 0 : 2);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    @(negedge clk);
    if (sel) if_b.dmem_req_valid = 1'b0;
    else     if_a.dmem_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if_a.dmem_req_valid = 1'b0;
    if_b.dmem_req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    last_a = 64'd0;
    last_b = 64'd0;
    rst    = 1'b0;
    if_a.dmem_req_valid = 1'b0; if_a.dmem_req_we = 1'b0; if_a.dmem_address = '0; if_a.dmem_dataIn = '0;
    if_b.dmem_req_valid = 1'b0; if_b.dmem_req_we = 1'b0; if_b.dmem_address = '0; if_b.dmem_dataIn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready_w2", {63'd0, if_a.dmem_req_ready}, 64'd1);
      check("idle_ready_w0", {63'd0, if_b.dmem_req_ready}, 64'd1);
      check("idle_valid_w2", {63'd0, if_a.dmem_resp_valid}, 64'd0);
      check("idle_valid_w0", {63'd0, if_b.dmem_resp_valid}, 64'd0);
      check("idle_data_w2", if_a.dmem_dataOut, 64'd0);
      check("idle_data_w0", if_b.dmem_dataOut, 64'd0);
    end

    // Store then load presented immediately: load is held off until the store's RESP cycle.
    issue(0, 1, 32'd5, 64'hDEADBEEF_01234567);
    check("ready_low_in_wait", {63'd0, if_a.dmem_req_ready}, 64'd0);
    issue(0, 0, 32'd5, 64'd0);

    // Held request during WAIT must not disturb the captured store to 7.
    issue(0, 1, 32'd7, 64'h0000_A5A5_A5A5_0000);
    check("ready_low_backpressure", {63'd0, if_a.dmem_req_ready}, 64'd0);
    issue(0, 1, 32'd8, 64'h7777_7777_0000_0001);
    issue(0, 0, 32'd7, 64'd0);
    issue(0, 0, 32'd8, 64'd0);

    // Out of range, including addresses whose low bits alias in-range words.
    issue(0, 1, 32'd0, 64'h0000_0000_0000_0123);
    issue(0, 1, 32'd256, 64'd1);
    issue(0, 1, 32'h0000_0105, 64'd2);
    issue(0, 0, 32'd256, 64'd0);
    issue(0, 0, 32'hFFFF_FFFF, 64'd0);
    issue(0, 0, 32'd0, 64'd0);
    issue(0, 0, 32'd5, 64'd0);
    idle(3);

    // Zero-wait streaming.
    issue(1, 1, 32'd1, 64'h1111);
    issue(1, 1, 32'd2, 64'h2222);
    issue(1, 1, 32'd3, 64'h3333);
    issue(1, 0, 32'd1, 64'd0);
    issue(1, 0, 32'd2, 64'd0);
    issue(1, 0, 32'd3, 64'd0);
    issue(1, 0, 32'd300, 64'd0);
    issue(1, 0, 32'd2, 64'd0);
    idle(3);

    // Reset during WAIT drops an in-flight store.
    issue(0, 1, 32'd9, 64'h11);
    issue(0, 0, 32'd9, 64'd0);
    issue(0, 1, 32'd9, 64'h55, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    last_a = 64'd0;
    last_b = 64'd0;
    idle(5);
    check("post_reset_data_w2", if_a.dmem_dataOut, 64'd0);
    check("post_reset_data_w0", if_b.dmem_dataOut, 64'd0);
    check("post_reset_valid_w2", {63'd0, if_a.dmem_resp_valid}, 64'd0);
    issue(0, 0, 32'd9, 64'd0);

    for (int t = 0; t < 20 && (q_a.size() != 0 || q_b.size() != 0); t++) @(negedge clk);
    idle(4);
    check("drain_w2", 64'(q_a.size()), 64'd0);
    check("drain_w0", 64'(q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
